// File: rtl/ines_loader_if.sv
// rtl/ines_loader_if.sv - byte stream input and PRG/CHR write ports of the iNES loader
interface ines_loader_if #(
  parameter int PRG_AW = 15,
  parameter int CHR_AW = 13
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              prg_we;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_wdata;
  logic              chr_we;
  logic [CHR_AW-1:0] chr_addr;
  logic [7:0]        chr_wdata;

  // loader side: consumes the byte stream, drives the ROM write ports
  modport master (
    input  in_data, in_valid,
    output in_ready,
    output prg_we, prg_addr, prg_wdata,
    output chr_we, chr_addr, chr_wdata
  );

  // host/memory side: supplies bytes, observes writes
  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  prg_we, prg_addr, prg_wdata,
    input  chr_we, chr_addr, chr_wdata
  );
endinterface

// File: rtl/ines_loader.sv
// rtl/ines_loader.sv - iNES image parser writing PRG and CHR bytes into ROM arrays
module ines_loader #(
  parameter int MAX_PRG_BANKS = 2,
  parameter int MAX_CHR_BANKS = 1,
  parameter int PRG_AW        = 15,
  parameter int CHR_AW        = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  ines_loader_if.master bus,
  output logic [7:0]    prg_banks,
  output logic [7:0]    chr_banks,
  output logic          mirror_v,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0] PRG_MAX = 9'(MAX_PRG_BANKS);
  localparam logic [8:0] CHR_MAX = 9'(MAX_CHR_BANKS);

  state_t            state, state_nx;
  logic [3:0]        hdr_cnt;
  logic [8:0]        trn_cnt;
  logic [PRG_AW:0]   prg_cnt;
  logic [CHR_AW:0]   chr_cnt;
  logic              trainer;
  logic              xfer;
  logic              hdr_bad;
  logic [7:0]        magic;
  logic [31:0]       prg_last;
  logic [31:0]       chr_last;
  logic              prg_end;
  logic              chr_end;

  assign bus.in_ready = (state == S_HEADER) || (state == S_TRAINER) ||
                        (state == S_PRG)    || (state == S_CHR);
  assign busy  = bus.in_ready;
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

  // a start pulse wins over a same-cycle handshake, so that byte never counts
  assign xfer = bus.in_valid && bus.in_ready && !start;

  // index of the last payload byte of each region, from the latched bank counts
  assign prg_last = ({24'd0, prg_banks} << 14) - 32'd1;
  assign chr_last = ({24'd0, chr_banks} << 13) - 32'd1;
  assign prg_end  = ({{(31-PRG_AW){1'b0}}, prg_cnt} == prg_last);
  assign chr_end  = ({{(31-CHR_AW){1'b0}}, chr_cnt} == chr_last);

  // header validation of the byte currently offered at index hdr_cnt
  always_comb begin
    hdr_bad = 1'b0;
    magic   = 8'h00;
    case (hdr_cnt[1:0])
      2'd0: magic = 8'h4E;
      2'd1: magic = 8'h45;
      2'd2: magic = 8'h53;
      default: magic = 8'h1A;
    endcase
    case (hdr_cnt)
      4'd0, 4'd1, 4'd2, 4'd3: hdr_bad = (bus.in_data != magic);
      4'd4: hdr_bad = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > PRG_MAX);
      4'd5: hdr_bad = ({1'b0, bus.in_data} > CHR_MAX);
      default: hdr_bad = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_HEADER;
    end else begin
      case (state)
        S_HEADER: begin
          if (xfer) begin
            if (hdr_bad)               state_nx = S_ERR;
            else if (hdr_cnt == 4'd15) state_nx = trainer ? S_TRAINER : S_PRG;
          end
        end
        S_TRAINER: if (xfer && (trn_cnt == 9'h1FF)) state_nx = S_PRG;
        S_PRG:     if (xfer && prg_end) state_nx = (chr_banks != 8'd0) ? S_CHR : S_DONE;
        S_CHR:     if (xfer && chr_end) state_nx = S_DONE;
        default:   state_nx = state;
      endcase
    end
  end

  // counters, latched header fields and registered write ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt       <= '0;
      trn_cnt       <= '0;
      prg_cnt       <= '0;
      chr_cnt       <= '0;
      trainer       <= 1'b0;
      prg_banks     <= 8'd0;
      chr_banks     <= 8'd0;
      mirror_v      <= 1'b0;
      bus.prg_we    <= 1'b0;
      bus.prg_addr  <= '0;
      bus.prg_wdata <= 8'd0;
      bus.chr_we    <= 1'b0;
      bus.chr_addr  <= '0;
      bus.chr_wdata <= 8'd0;
    end else begin
      bus.prg_we <= 1'b0;
      bus.chr_we <= 1'b0;
      if (start) begin
        hdr_cnt   <= '0;
        trn_cnt   <= '0;
        prg_cnt   <= '0;
        chr_cnt   <= '0;
        trainer   <= 1'b0;
        prg_banks <= 8'd0;
        chr_banks <= 8'd0;
        mirror_v  <= 1'b0;
      end else if (xfer) begin
        case (state)
          S_HEADER: begin
            hdr_cnt <= hdr_cnt + 4'd1;
            case (hdr_cnt)
              4'd4: prg_banks <= bus.in_data;
              4'd5: chr_banks <= bus.in_data;
              4'd6: begin
                mirror_v <= bus.in_data[0];
                trainer  <= bus.in_data[2];
              end
              default: ;
            endcase
          end
          S_TRAINER: trn_cnt <= trn_cnt + 9'd1;
          S_PRG: begin
            bus.prg_we    <= 1'b1;
            bus.prg_addr  <= prg_cnt[PRG_AW-1:0];
            bus.prg_wdata <= bus.in_data;
            prg_cnt       <= prg_cnt + 1'b1;
          end
          S_CHR: begin
            bus.chr_we    <= 1'b1;
            bus.chr_addr  <= chr_cnt[CHR_AW-1:0];
            bus.chr_wdata <= bus.in_data;
            chr_cnt       <= chr_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ines_loader.md
Name: ines_loader

Overview:
- Writer side of the cartridge ROM store: consumes an iNES image as a byte stream and writes PRG and CHR data into the ROM arrays that the CPU and PPU later read.
- Parses the 16-byte header, validates it, skips an optional 512-byte trainer, then streams PRG bytes to the PRG write port and CHR bytes to the CHR write port.
- Sits between the host byte source (UART/SPI bridge) and the ROM memories; holds the NES in reset until `done`.

Parameters:
- MAX_PRG_BANKS, 2, maximum accepted PRG size in 16 KiB units.
- MAX_CHR_BANKS, 1, maximum accepted CHR size in 8 KiB units.
- PRG_AW, 15, PRG write address width; must cover MAX_PRG_BANKS*16384.
- CHR_AW, 13, CHR write address width; must cover MAX_CHR_BANKS*8192.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from any state.
- in_data  in  8  image byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
- prg_we  out  1  PRG write strobe, one cycle per byte.
- prg_addr  out  PRG_AW  PRG write address.
- prg_wdata  out  8  PRG write data.
- chr_we  out  1  CHR write strobe.
- chr_addr  out  CHR_AW  CHR write address.
- chr_wdata  out  8  CHR write data.
- prg_banks  out  8  header byte 4, latched.
- chr_banks  out  8  header byte 5, latched.
- mirror_v  out  1  header byte 6 bit 0 (1 = vertical mirroring).
- busy  out  1  a load is in progress.
- done  out  1  the image was loaded successfully; stays high.
- error  out  1  the header was rejected; stays high.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including in_ready, write strobes, addresses, data, latched header fields, busy, done and error.
- States: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERR.
- in_ready = 1 only in HEADER, TRAINER, PRG and CHR.
- busy = 1 in the same four states.
- start in any state: clear done and error, zero all counters, go to HEADER next cycle. start takes priority over a same-cycle transfer, and that byte is discarded.
- HEADER:
  - A 4-bit counter indexes the accepted bytes.
  - Bytes 0..3 must be 0x4E, 0x45, 0x53, 0x1A. A mismatch goes to ERR on the cycle after the offending byte.
  - Byte 4 is latched to prg_banks. A value of 0 or > MAX_PRG_BANKS goes to ERR.
  - Byte 5 is latched to chr_banks. A value > MAX_CHR_BANKS goes to ERR.
  - Byte 6: bit 0 goes to mirror_v; bit 2 is latched as the trainer flag.
  - Bytes 7..15 are ignored.
  - After byte 15: go to TRAINER if the trainer flag is set, otherwise PRG.
- TRAINER: accept and discard exactly 512 bytes (9-bit counter), then go to PRG.
- PRG:
  - Each transfer drives prg_we=1, prg_addr=count and prg_wdata=byte on the next cycle (registered; latency 1).
  - The counter increments per transfer.
  - After byte prg_banks*16384-1: go to CHR if chr_banks != 0, otherwise DONE.
- CHR: same scheme on the chr_* ports, ending after byte chr_banks*8192-1. Then go to DONE.
- Write strobes are high for exactly one cycle per accepted byte. prg_addr/prg_wdata hold their last value when the strobe is low; the same applies to the chr_* ports.
- The final write strobe occurs in the same cycle that done first rises.
- in_valid gaps: no write and no counter change. Back-to-back transfers give back-to-back strobes.
- DONE: done=1 and in_ready=0. Any extra bytes are ignored (not accepted).
- ERR: error=1 and in_ready=0 until start or reset. No write strobe is ever issued in a load that ends in ERR.
- Reset mid-load: immediately returns to the reset state. Partially written memory is not cleared.
- Counter widths: PRG counter PRG_AW+1 bits, CHR counter CHR_AW+1 bits. No counter ever wraps within a legal image.

Test Plan:
- Valid image, 1 PRG bank, 1 CHR bank, no trainer, in_valid held high, PRG bytes = file offset[7:0]:
  - File offset 0x10 gives prg_we with addr 0x0000 and data 0x10.
  - File offset 0x4010 gives chr_we with addr 0x0000 and data 0x10.
  - Exactly 16384 PRG strobes and 8192 CHR strobes.
  - done rises with the final write, 24592 transfers after start.
- Trainer flag set (byte 6 = 0x04):
  - The first 512 bytes after the header produce no strobes.
  - The byte at file offset 0x210 is written to prg_addr 0.
  - mirror_v = 0.
- Header byte 3 = 0x00:
  - error=1 and in_ready=0 on the cycle after byte 3 is accepted.
  - No strobes.
  - A later start followed by a good image loads normally with error cleared.
- prg_banks=0, and separately chr_banks=2 with MAX_CHR_BANKS=1 → ERR; chr_banks=0 → DONE directly after the PRG bytes, with no chr_we.
- Random in_valid gaps of 0..5 cycles: write addresses stay contiguous, and the data matches the stream byte-for-byte.
- rst_n pulsed low mid-PRG: all outputs are 0 immediately. A subsequent start reloads from header byte 0.
